// File: rtl/bsh_pkg.sv
// Shared types for the pipelined barrel shifter: operation encoding and its width.
package bsh_pkg;

  localparam int BSH_OP_W = 2;

  typedef enum logic [BSH_OP_W-1:0] {
    BSH_SLL = 2'b00,
    BSH_SRL = 2'b01,
    BSH_SRA = 2'b10,
    BSH_ROR = 2'b11
  } bsh_op_t;

endpackage

// File: rtl/bsh_if.sv
// Valid/ready bus between a requester and the pipelined barrel shifter.
// Optional status flags (out_zero, out_carry) exist only when BSH_FLAGS_EN is defined.
interface bsh_if #(
  parameter int WIDTH = 32
);
  import bsh_pkg::*;

  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shift_amt;
  bsh_op_t            op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   data_out;
`ifdef BSH_FLAGS_EN
  logic               out_zero;
  logic               out_carry;
`endif

  modport master (
    output in_valid, data_in, shift_amt, op, out_ready,
    input  in_ready, out_valid, data_out
`ifdef BSH_FLAGS_EN
    , input out_zero, out_carry
`endif
  );

  modport slave (
    input  in_valid, data_in, shift_amt, op, out_ready,
    output in_ready, out_valid, data_out
`ifdef BSH_FLAGS_EN
    , output out_zero, out_carry
`endif
  );

endinterface

// File: rtl/bsh_stage.sv
// One combinational log2 shifter stage: shifts or rotates by DIST when enabled.
module bsh_stage
  import bsh_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  bsh_op_t          i_op,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_data
);

  always_comb begin
    o_data = i_data;
    if (i_enable) begin
      case (i_op)
        BSH_SLL: o_data = i_data << DIST;
        BSH_SRL: o_data = i_data >> DIST;
        BSH_SRA: o_data = $signed(i_data) >>> DIST;
        BSH_ROR: o_data = {i_data[DIST-1:0], i_data[WIDTH-1:DIST]};
        default: o_data = i_data;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one log2 stage per register, fixed latency of $clog2(WIDTH) cycles.
// Define BSH_FLAGS_EN to add the out_zero/out_carry status flags aligned with data_out.
module pipelined_barrel_shifter
  import bsh_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic  clk,
  input logic  rst_n,
  bsh_if.slave bus
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int LAST    = SHAMT_W - 1;

  logic               r_valid    [SHAMT_W];
  logic [WIDTH-1:0]   r_data     [SHAMT_W];
  bsh_op_t            r_op       [LAST];
  logic [SHAMT_W-1:0] r_amt      [LAST];
  logic [WIDTH-1:0]   w_stageIn  [SHAMT_W];
  logic [WIDTH-1:0]   w_stageOut [SHAMT_W];
  bsh_op_t            w_stageOp  [SHAMT_W];
  logic               w_stageEn  [SHAMT_W];
  logic               w_stall;

  assign w_stall       = r_valid[LAST] & ~bus.out_ready;
  assign bus.in_ready  = ~w_stall;
  assign bus.out_valid = r_valid[LAST];
  assign bus.data_out  = r_data[LAST];

  // Stage k consumes amount bit k; stage 0 works straight off the input port.
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_stageIn[k] = bus.data_in;
      assign w_stageOp[k] = bus.op;
      assign w_stageEn[k] = bus.shift_amt[0];
    end else begin : g_tail
      assign w_stageIn[k] = r_data[k-1];
      assign w_stageOp[k] = r_op[k-1];
      assign w_stageEn[k] = r_amt[k-1][k];
    end

    bsh_stage #(
      .WIDTH (WIDTH),
      .DIST  (2 ** k)
    ) u_stage (
      .i_data   (w_stageIn[k]),
      .i_op     (w_stageOp[k]),
      .i_enable (w_stageEn[k]),
      .o_data   (w_stageOut[k])
    );
  end

`ifdef BSH_FLAGS_EN
  logic [SHAMT_W-1:0] w_carryIdx;
  logic               w_carryIn;
  logic               r_carry [SHAMT_W];

  // WIDTH is a power of two, so WIDTH-amt wraps naturally in SHAMT_W bits.
  always_comb begin
    w_carryIdx = (bus.op == BSH_SLL) ? (SHAMT_W'(0) - bus.shift_amt)
                                     : (bus.shift_amt - SHAMT_W'(1));
    w_carryIn  = (bus.shift_amt != '0) ? bus.data_in[w_carryIdx] : 1'b0;
  end

  assign bus.out_zero  = r_valid[LAST] & (r_data[LAST] == '0);
  assign bus.out_carry = r_valid[LAST] & r_carry[LAST];
`endif

  // A stall freezes every stage, bubbles included, so latency stays fixed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < SHAMT_W; k++) begin
        r_valid[k] <= 1'b0;
        r_data[k]  <= '0;
`ifdef BSH_FLAGS_EN
        r_carry[k] <= 1'b0;
`endif
      end
      for (int k = 0; k < LAST; k++) begin
        r_op[k]  <= BSH_SLL;
        r_amt[k] <= '0;
      end
    end else if (!w_stall) begin
      r_valid[0] <= bus.in_valid;
      r_op[0]    <= bus.op;
      r_amt[0]   <= bus.shift_amt;
`ifdef BSH_FLAGS_EN
      r_carry[0] <= w_carryIn;
      for (int k = 1; k < SHAMT_W; k++) r_carry[k] <= r_carry[k-1];
`endif
      for (int k = 1; k < SHAMT_W; k++) r_valid[k] <= r_valid[k-1];
      for (int k = 1; k < LAST; k++) begin
        r_op[k]  <= r_op[k-1];
        r_amt[k] <= r_amt[k-1];
      end
      for (int k = 0; k < SHAMT_W; k++) r_data[k] <= w_stageOut[k];
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter: directed steps plus random traffic
// against a queue-based reference model; flag checks are compiled in with BSH_FLAGS_EN.
module tb_pipelined_barrel_shifter;
  import bsh_pkg::*;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int LAT     = SHAMT_W;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             carry;
    int               accCyc;
    int               accStalls;
  } expEntry_t;

  logic clk = 1'b0;
  logic rst_n;

  bsh_if #(.WIDTH(WIDTH)) bus();

  pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  expEntry_t        expQ[$];
  int               checks    = 0;
  int               failures  = 0;
  int               cyc       = 0;
  int               stallCnt  = 0;
  logic             prevStall = 1'b0;
  logic [WIDTH-1:0] heldData  = '0;

  function automatic logic [WIDTH-1:0] refShift(input logic [WIDTH-1:0] d, input int amt,
                                                input bsh_op_t op);
    logic [2*WIDTH-1:0] wide;
    case (op)
      BSH_SLL: return d << amt;
      BSH_SRL: return d >> amt;
      BSH_SRA: begin
        wide = {{WIDTH{d[WIDTH-1]}}, d};
        wide = wide >> amt;
        return wide[WIDTH-1:0];
      end
      default: begin
        wide = {d, d};
        wide = wide >> amt;
        return wide[WIDTH-1:0];
      end
    endcase
  endfunction

  function automatic logic refCarry(input logic [WIDTH-1:0] d, input int amt, input bsh_op_t op);
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] res;
    if (amt == 0) return 1'b0;
    case (op)
      BSH_SLL: begin
        ext = {1'b0, d} << amt;
        return ext[WIDTH];
      end
      BSH_ROR: begin
        res = refShift(d, amt, op);
        return res[WIDTH-1];
      end
      default: begin
        ext = {d, 1'b0} >> amt;
        return ext[0];
      end
    endcase
  endfunction

  task automatic checkEq(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Output-side checks for the current cycle, sampled 1ns after the falling edge.
  task automatic checkOutput(input logic outReady, input logic stall);
    expEntry_t e;
    checkBit("in_ready", bus.in_ready, ~stall);
    if (prevStall) begin
      checkEq("hold_data_out", bus.data_out, heldData);
      checkBit("hold_out_valid", bus.out_valid, 1'b1);
    end
    if (bus.out_valid && outReady) begin
      checkBit("unexpected_output", expQ.size() != 0, 1'b1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkEq("data_out", bus.data_out, e.data);
        checkInt("latency", cyc - e.accCyc, LAT + stallCnt - e.accStalls);
`ifdef BSH_FLAGS_EN
        checkBit("out_carry", bus.out_carry, e.carry);
        checkBit("out_zero", bus.out_zero, e.data == '0);
`endif
      end
    end
  endtask

  task automatic applyStimulus(input logic inValid, input logic [WIDTH-1:0] d,
                               input logic [SHAMT_W-1:0] amt, input bsh_op_t op,
                               input logic outReady, input logic [WIDTH-1:0] expData,
                               input logic expCarry);
    logic      stall;
    expEntry_t e;
    @(negedge clk);
    bus.in_valid  = inValid;
    bus.data_in   = d;
    bus.shift_amt = amt;
    bus.op        = op;
    bus.out_ready = outReady;
    #1;
    stall = bus.out_valid & ~outReady;
    checkOutput(outReady, stall);
    if (inValid && !stall) begin
      e.data      = expData;
      e.carry     = expCarry;
      e.accCyc    = cyc;
      e.accStalls = stallCnt;
      expQ.push_back(e);
    end
    if (stall) begin
      stallCnt++;
      heldData = bus.data_out;
    end
    prevStall = stall;
    cyc++;
    @(posedge clk);
  endtask

  task automatic sendOp(input logic inValid, input logic [WIDTH-1:0] d,
                        input logic [SHAMT_W-1:0] amt, input bsh_op_t op, input logic outReady);
    applyStimulus(inValid, d, amt, op, outReady, refShift(d, int'(amt), op),
                  refCarry(d, int'(amt), op));
  endtask

  task automatic sendExp(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] amt,
                         input bsh_op_t op, input logic [WIDTH-1:0] expData, input logic expCarry);
    applyStimulus(1'b1, d, amt, op, 1'b1, expData, expCarry);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, BSH_SLL, 1'b1, '0, 1'b0);
  endtask

  task automatic drain();
    idle(LAT + 3);
    checkInt("drain_queue_empty", expQ.size(), 0);
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    expQ.delete();
    prevStall = 1'b0;
    checkBit("reset_out_valid", bus.out_valid, 1'b0);
    checkEq("reset_data_out", bus.data_out, '0);
    checkBit("reset_in_ready", bus.in_ready, 1'b1);
`ifdef BSH_FLAGS_EN
    checkBit("reset_out_zero", bus.out_zero, 1'b0);
    checkBit("reset_out_carry", bus.out_carry, 1'b0);
`endif
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    bsh_op_t          o;
    int               stallsBefore;

    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.shift_amt = '0;
    bus.op        = BSH_SLL;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    applyReset();

    $display("[TB] modes on 32'h8000_00F1 by 4");
    d = 32'h8000_00F1;
    sendExp(d, 5'd4, BSH_SLL, 32'h0000_0F10, refCarry(d, 4, BSH_SLL));
    sendExp(d, 5'd4, BSH_SRL, 32'h0800_000F, refCarry(d, 4, BSH_SRL));
    sendExp(d, 5'd4, BSH_SRA, 32'hF800_000F, refCarry(d, 4, BSH_SRA));
    sendExp(d, 5'd4, BSH_ROR, 32'h1800_000F, refCarry(d, 4, BSH_ROR));
    drain();

    $display("[TB] back-to-back amounts 0..7");
    for (int a = 0; a < 8; a++) begin
      d = $urandom;
      o = bsh_op_t'($urandom_range(0, 3));
      sendOp(1'b1, d, SHAMT_W'(a), o, 1'b1);
    end
    drain();

    $display("[TB] backpressure mid-stream");
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      o = bsh_op_t'($urandom_range(0, 3));
      sendOp(1'b1, d, SHAMT_W'($urandom_range(0, WIDTH - 1)), o, 1'b1);
    end
    stallsBefore = stallCnt;
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      sendOp(1'b1, d, SHAMT_W'($urandom_range(0, WIDTH - 1)), BSH_SRA, 1'b0);
    end
    checkInt("stall_cycles", stallCnt - stallsBefore, 3);
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      o = bsh_op_t'($urandom_range(0, 3));
      sendOp(1'b1, d, SHAMT_W'($urandom_range(0, WIDTH - 1)), o, 1'b1);
    end
    drain();

    $display("[TB] boundaries");
    for (int m = 0; m < 4; m++) begin
      d = $urandom;
      sendExp(d, '0, bsh_op_t'(m), d, 1'b0);
    end
    sendExp(32'h8000_0000, 5'd31, BSH_SRA, 32'hFFFF_FFFF, 1'b0);
    sendExp(32'h0000_0001, 5'd31, BSH_SLL, 32'h8000_0000, 1'b0);
    sendExp(32'h8000_0000, 5'd1, BSH_SLL, 32'h0000_0000, 1'b1);
    sendExp(32'h0000_0002, 5'd1, BSH_SRL, 32'h0000_0001, 1'b0);
    drain();

    $display("[TB] reset with three ops in flight");
    for (int i = 0; i < 3; i++) begin
      d = $urandom | 32'h1;
      sendOp(1'b1, d, SHAMT_W'(i), BSH_ROR, 1'b1);
    end
    applyReset();
    idle(LAT + 4);

    $display("[TB] random traffic");
    for (int i = 0; i < 80; i++) begin
      d = $urandom;
      o = bsh_op_t'($urandom_range(0, 3));
      sendOp($urandom_range(0, 3) != 0, d, SHAMT_W'($urandom_range(0, WIDTH - 1)), o,
             $urandom_range(0, 3) != 0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
